// File: rtl/pwm_regs.sv
// PWM timebase and duty register stage for out_logic.
// Free-running period counter, period-start set strobe, and a double-buffered duty compare value.
module pwm_regs #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned PERIOD = 400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_wr,
    output logic             duty_ack,
    output logic             duty_pend,
    output logic [WIDTH-1:0] cnt_pwm,
    output logic             E,
    output logic [WIDTH-1:0] TE,
    output logic             per_end
);

    localparam logic [WIDTH-1:0] PER_MAX  = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic [WIDTH-1:0] duty_clamped;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] te_nxt;
    logic             e_nxt;
    logic             per_end_nxt;
    logic             pend_nxt;
    logic             ack_nxt;
    logic             load;

    // Duty at or above the period saturates to PERIOD, which the counter never reaches (100% on).
    assign duty_clamped = (duty_in >= PER_MAX) ? PER_MAX : duty_in;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt_pwm   <= '0;
            TE        <= '0;
            E         <= 1'b0;
            per_end   <= 1'b0;
            duty_pend <= 1'b0;
            duty_ack  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            cnt_pwm   <= cnt_nxt;
            TE        <= te_nxt;
            E         <= e_nxt;
            per_end   <= per_end_nxt;
            duty_pend <= pend_nxt;
            duty_ack  <= ack_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        shadow_nxt  = duty_wr ? duty_clamped : shadow;
        ack_nxt     = duty_wr;
        pend_nxt    = duty_pend | duty_wr;
        cnt_nxt     = '0;
        te_nxt      = '0;
        e_nxt       = 1'b0;
        per_end_nxt = 1'b0;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                    te_nxt    = shadow;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (cnt_pwm == CNT_LAST) begin
                    load   = 1'b1;
                    te_nxt = duty_pend ? shadow : TE;
                end else begin
                    cnt_nxt = cnt_pwm + WIDTH'(1);
                    te_nxt  = TE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A write landing on a load edge only reaches the shadow; it stays pending for the next period.
        if (load) begin
            e_nxt    = (te_nxt != '0);
            pend_nxt = duty_wr;
        end

        per_end_nxt = (state_nxt == RUN) && (cnt_nxt == CNT_LAST);
    end

endmodule

// File: tb/tb_pwm_regs.sv
// Self-checking bench for pwm_regs: directed sequences, a duty vector table and an ack scoreboard.
module tb_pwm_regs;

    localparam int unsigned WIDTH  = 9;
    localparam int unsigned PERIOD = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] duty_in;
    logic             duty_wr;
    logic             duty_ack;
    logic             duty_pend;
    logic [WIDTH-1:0] cnt_pwm;
    logic             E;
    logic [WIDTH-1:0] TE;
    logic             per_end;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;
    int ack_q[$];

    typedef struct {
        int din;
        int te;
        int e;
    } vec_t;
    vec_t tbl[6];

    pwm_regs #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .duty_in  (duty_in),
        .duty_wr  (duty_wr),
        .duty_ack (duty_ack),
        .duty_pend(duty_pend),
        .cnt_pwm  (cnt_pwm),
        .E        (E),
        .TE       (TE),
        .per_end  (per_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write; the scoreboard expects duty_ack on the cycle after the sampling edge.
    task automatic write(input int v);
        duty_in = WIDTH'(v);
        duty_wr = 1'b1;
        ack_q.push_back(cyc + 1);
        step();
        duty_wr = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (int'(cnt_pwm) != target && n < 2 * PERIOD);
        chk($sformatf("wait_cnt_%0d", target), int'(cnt_pwm), target);
    endtask

    // Ack scoreboard: pops an expected pulse on its cycle, otherwise duty_ack must be low.
    always @(posedge clk) begin
        #2;
        if (mon_on) begin
            if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                chk("duty_ack_pulse", int'(duty_ack), 1);
                void'(ack_q.pop_front());
            end else begin
                chk("duty_ack_idle", int'(duty_ack), 0);
            end
        end
    end

    initial begin
        int e_cnt;
        int prev_te;

        tbl[0] = '{din: 0,   te: 0,   e: 0};
        tbl[1] = '{din: 450, te: 400, e: 1};
        tbl[2] = '{din: 511, te: 400, e: 1};
        tbl[3] = '{din: 399, te: 399, e: 1};
        tbl[4] = '{din: 1,   te: 1,   e: 1};
        tbl[5] = '{din: 100, te: 100, e: 1};

        rst     = 1'b1;
        en      = 1'b0;
        duty_in = '0;
        duty_wr = 1'b0;

        // Reset and parked behaviour.
        repeat (3) step();
        chk("rst_cnt", int'(cnt_pwm), 0);
        chk("rst_te", int'(TE), 0);
        chk("rst_e", int'(E), 0);
        chk("rst_ack", int'(duty_ack), 0);
        chk("rst_pend", int'(duty_pend), 0);
        chk("rst_per_end", int'(per_end), 0);
        rst    = 1'b0;
        mon_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_cnt", int'(cnt_pwm), 0);
            chk("idle_e", int'(E), 0);
        end

        // Write 100 then start.
        write(100);
        chk("pend_after_wr", int'(duty_pend), 1);
        en = 1'b1;
        step();
        chk("start_cnt", int'(cnt_pwm), 0);
        chk("start_te", int'(TE), 100);
        chk("start_e", int'(E), 1);
        chk("start_pend", int'(duty_pend), 0);
        e_cnt = 0;
        for (int i = 1; i <= int'(PERIOD); i++) begin
            step();
            chk("run_cnt", int'(cnt_pwm), i % int'(PERIOD));
            chk("run_per_end", int'(per_end), (i == int'(PERIOD) - 1) ? 1 : 0);
            if (E) e_cnt++;
        end
        chk("e_per_period", e_cnt, 1);
        chk("wrap_e", int'(E), 1);

        // Mid-period write is held in the shadow until the wrap.
        wait_cnt(37);
        write(250);
        chk("mid_pend", int'(duty_pend), 1);
        wait_cnt(int'(PERIOD) - 1);
        chk("mid_te_old", int'(TE), 100);
        wait_cnt(0);
        chk("mid_te_new", int'(TE), 250);
        chk("mid_e", int'(E), 1);
        chk("mid_pend_clr", int'(duty_pend), 0);

        // Duty vector table, including zero and clamped values.
        prev_te = 250;
        foreach (tbl[k]) begin
            wait_cnt(50);
            write(tbl[k].din);
            wait_cnt(int'(PERIOD) - 1);
            chk($sformatf("tbl%0d_te_hold", k), int'(TE), prev_te);
            chk($sformatf("tbl%0d_pend", k), int'(duty_pend), 1);
            wait_cnt(0);
            chk($sformatf("tbl%0d_te", k), int'(TE), tbl[k].te);
            chk($sformatf("tbl%0d_e", k), int'(E), tbl[k].e);
            chk($sformatf("tbl%0d_pend_clr", k), int'(duty_pend), 0);
            prev_te = tbl[k].te;
        end

        // Write on the wrap edge: old value applies now, new one a period later.
        wait_cnt(int'(PERIOD) - 1);
        write(300);
        chk("wrapwr_cnt", int'(cnt_pwm), 0);
        chk("wrapwr_te", int'(TE), 100);
        chk("wrapwr_e", int'(E), 1);
        chk("wrapwr_pend", int'(duty_pend), 1);
        wait_cnt(0);
        chk("wrapwr_te_next", int'(TE), 300);
        chk("wrapwr_pend_clr", int'(duty_pend), 0);

        // Park mid-period, then restart.
        wait_cnt(123);
        en = 1'b0;
        step();
        chk("park_cnt", int'(cnt_pwm), 0);
        chk("park_te", int'(TE), 0);
        chk("park_e", int'(E), 0);
        chk("park_per_end", int'(per_end), 0);
        repeat (5) step();
        chk("park_hold_cnt", int'(cnt_pwm), 0);
        en = 1'b1;
        step();
        chk("restart_cnt", int'(cnt_pwm), 0);
        chk("restart_te", int'(TE), 300);
        chk("restart_e", int'(E), 1);

        // en=0 on the wrap edge wins over a pending TE load.
        wait_cnt(200);
        write(77);
        wait_cnt(int'(PERIOD) - 1);
        en = 1'b0;
        step();
        chk("wrapoff_cnt", int'(cnt_pwm), 0);
        chk("wrapoff_te", int'(TE), 0);
        chk("wrapoff_pend", int'(duty_pend), 1);
        en = 1'b1;
        step();
        chk("wrapoff_re_te", int'(TE), 77);
        chk("wrapoff_re_e", int'(E), 1);
        chk("wrapoff_re_pend", int'(duty_pend), 0);

        // Reset mid-run drops a simultaneous write.
        wait_cnt(250);
        rst     = 1'b1;
        duty_in = WIDTH'(5);
        duty_wr = 1'b1;
        step();
        duty_wr = 1'b0;
        chk("midrst_cnt", int'(cnt_pwm), 0);
        chk("midrst_te", int'(TE), 0);
        chk("midrst_e", int'(E), 0);
        chk("midrst_ack", int'(duty_ack), 0);
        chk("midrst_pend", int'(duty_pend), 0);
        chk("midrst_per_end", int'(per_end), 0);
        rst = 1'b0;
        step();
        chk("postrst_cnt", int'(cnt_pwm), 0);
        chk("postrst_te", int'(TE), 0);
        chk("postrst_e", int'(E), 0);
        step();
        chk("postrst_cnt1", int'(cnt_pwm), 1);

        repeat (2) step();
        chk("ack_q_drained", ack_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
